// File: rtl/spi_arbiter_if.sv
// Bus bundle for the shared SPI arbiter: requester handshake side plus the
// serial lines to the peripherals. The arbiter uses the master modport; the
// requesters/peripheral side (or a bench) uses the slave modport.
interface spi_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int NUM_SLAVES = 3,
    parameter int TX_WIDTH   = 36,
    parameter int RX_WIDTH   = 16
);
    localparam int TGT_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int LEN_W = $clog2(TX_WIDTH + 1);

    logic [NUM_REQ-1:0]                i_req;
    logic [NUM_REQ-1:0][TGT_W-1:0]     i_target;
    logic [NUM_REQ-1:0][TX_WIDTH-1:0]  i_tx_data;
    logic [NUM_REQ-1:0][LEN_W-1:0]     i_tx_len;
    logic [NUM_REQ-1:0]                o_grant;
    logic [NUM_REQ-1:0]                o_done;
    logic                              o_error;
    logic [RX_WIDTH-1:0]               o_rx_data;
    logic [NUM_SLAVES-1:0]             o_nss;
    logic                              o_mosi;
    logic                              i_miso;

    modport master (
        input  i_req, i_target, i_tx_data, i_tx_len, i_miso,
        output o_grant, o_done, o_error, o_rx_data, o_nss, o_mosi
    );

    modport slave (
        output i_req, i_target, i_tx_data, i_tx_len, i_miso,
        input  o_grant, o_done, o_error, o_rx_data, o_nss, o_mosi
    );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin SPI master shared by several requesters. One owner at a time is
// granted; its packet is shifted out LSB first to the selected peripheral, a
// fixed-width response is shifted back in, and a done pulse returns the result.
module spi_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int NUM_SLAVES = 3,
    parameter int TX_WIDTH   = 36,
    parameter int RX_WIDTH   = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic          i_clock,
    input  logic          i_reset,
    spi_arbiter_if.master bus
);
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TGT_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int LEN_W  = $clog2(TX_WIDTH + 1);
    localparam int RXC_W  = (RX_WIDTH > 1) ? $clog2(RX_WIDTH) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [5:0] S_IDLE      = 6'b000001;
    localparam logic [5:0] S_SEND      = 6'b000010;
    localparam logic [5:0] S_SENDING   = 6'b000100;
    localparam logic [5:0] S_RECEIVE   = 6'b001000;
    localparam logic [5:0] S_RECEIVING = 6'b010000;
    localparam logic [5:0] S_DONE      = 6'b100000;

    logic [5:0]          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [TGT_W-1:0]    target_q, target_d;
    logic [TX_WIDTH-1:0] data_q, data_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [RXC_W-1:0]    rx_cnt_q, rx_cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [RX_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic                err_q, err_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                error_q, error_d;
    logic [RX_WIDTH-1:0] rx_data_q, rx_data_d;

    logic                pick_valid;
    logic [PTR_W-1:0]    pick_idx;
    logic [PTR_W:0]      cand;
    logic [TGT_W-1:0]    sel_target;
    logic [LEN_W-1:0]    sel_len;
    logic                sel_bad;
    logic [NUM_SLAVES-1:0] nss;
    logic                mosi;

    // Round-robin pick: first requester at or after the pointer, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (cand >= (PTR_W + 1)'(NUM_REQ)) begin
                cand = cand - (PTR_W + 1)'(NUM_REQ);
            end
            if (bus.i_req[cand[PTR_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[PTR_W-1:0];
            end
        end
        sel_target = bus.i_target[pick_idx];
        sel_len    = bus.i_tx_len[pick_idx];
        sel_bad    = (int'(sel_target) >= NUM_SLAVES) || (sel_len == '0) ||
                     (int'(sel_len) > TX_WIDTH);
    end

    // Transaction sequencer: grant, handshake, shift out, handshake, shift in, report.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        target_d   = target_q;
        data_d     = data_q;
        len_d      = len_q;
        bit_cnt_d  = bit_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        wait_d     = '0;
        rx_shift_d = rx_shift_q;
        err_d      = err_q;
        grant_d    = grant_q;
        done_d     = '0;
        error_d    = 1'b0;
        rx_data_d  = rx_data_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    owner_d    = pick_idx;
                    target_d   = sel_target;
                    data_d     = bus.i_tx_data[pick_idx];
                    len_d      = sel_len;
                    grant_d    = NUM_REQ'(1) << pick_idx;
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                    rx_cnt_d   = '0;
                    err_d      = sel_bad;
                    state_d    = sel_bad ? S_DONE : S_SEND;
                end
            end
            S_SEND: begin
                if (!bus.i_miso) begin
                    state_d   = S_SENDING;
                    bit_cnt_d = '0;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d    = S_DONE;
                    err_d      = 1'b1;
                    rx_shift_d = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_SENDING: begin
                bit_cnt_d = bit_cnt_q + LEN_W'(1);
                if (bit_cnt_q == len_q - LEN_W'(1)) begin
                    state_d = S_RECEIVE;
                end
            end
            S_RECEIVE: begin
                if (bus.i_miso) begin
                    state_d  = S_RECEIVING;
                    rx_cnt_d = '0;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d    = S_DONE;
                    err_d      = 1'b1;
                    rx_shift_d = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_RECEIVING: begin
                rx_shift_d[rx_cnt_q] = bus.i_miso;
                rx_cnt_d = rx_cnt_q + RXC_W'(1);
                if (rx_cnt_q == RXC_W'(RX_WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d    = NUM_REQ'(1) << owner_q;
                error_d   = err_q;
                rx_data_d = rx_shift_q;
                grant_d   = '0;
                ptr_d     = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Serial lines decode straight from state so a reset releases nss immediately.
    always_comb begin
        nss  = '1;
        mosi = 1'b0;
        if ((state_q == S_SEND) || (state_q == S_SENDING) ||
            (state_q == S_RECEIVE) || (state_q == S_RECEIVING)) begin
            nss = ~(NUM_SLAVES'(1) << target_q);
        end
        if (state_q == S_SEND) begin
            mosi = 1'b1;
        end else if (state_q == S_SENDING) begin
            mosi = data_q[bit_cnt_q];
        end
    end

    // State, counters and registered outputs; reset aborts any transaction.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            target_q   <= '0;
            data_q     <= '0;
            len_q      <= '0;
            bit_cnt_q  <= '0;
            rx_cnt_q   <= '0;
            wait_q     <= '0;
            rx_shift_q <= '0;
            err_q      <= 1'b0;
            grant_q    <= '0;
            done_q     <= '0;
            error_q    <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            target_q   <= target_d;
            data_q     <= data_d;
            len_q      <= len_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            wait_q     <= wait_d;
            rx_shift_q <= rx_shift_d;
            err_q      <= err_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            error_q    <= error_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign bus.o_grant   = grant_q;
    assign bus.o_done    = done_q;
    assign bus.o_error   = error_q;
    assign bus.o_rx_data = rx_data_q;
    assign bus.o_nss     = nss;
    assign bus.o_mosi    = mosi;
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a small behavioural SPI peripheral that
// acknowledges, captures the mosi packet and returns a programmed response.
module tb_spi_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic        slv_ack;
    int          slv_len;
    logic [15:0] slv_resp;
    logic [35:0] slv_cap;
    int          slv_cnt;
    int          slv_phase;
    logic [2:0]  nss_low_mask;
    int          mask_gen;
    int          seen_gen;

    int          cycles;
    logic [1:0]  first_grant;
    int          extra;

    spi_arbiter_if #(.NUM_REQ(2), .NUM_SLAVES(3), .TX_WIDTH(36), .RX_WIDTH(16)) bus ();

    spi_arbiter #(
        .NUM_REQ(2), .NUM_SLAVES(3), .TX_WIDTH(36), .RX_WIDTH(16), .TIMEOUT(64)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural peripheral: ack in SEND, capture mosi, raise miso in RECEIVE, send response LSB first.
    always @(negedge clk) begin
        if (mask_gen != seen_gen) begin
            nss_low_mask = 3'b000;
            seen_gen = mask_gen;
        end
        if (bus.o_nss == 3'b111) begin
            slv_phase = 0;
            bus.i_miso = 1'b1;
        end else begin
            nss_low_mask = nss_low_mask | ~bus.o_nss;
            case (slv_phase)
                0: begin
                    if (slv_ack) begin
                        bus.i_miso = 1'b0;
                        slv_phase = 1;
                        slv_cnt = 0;
                        slv_cap = '0;
                    end
                end
                1: begin
                    slv_cap[slv_cnt] = bus.o_mosi;
                    slv_cnt++;
                    if (slv_cnt == slv_len) begin
                        bus.i_miso = 1'b1;
                        slv_phase = 2;
                    end
                end
                2: begin
                    slv_phase = 3;
                    slv_cnt = 0;
                end
                3: begin
                    bus.i_miso = slv_resp[slv_cnt];
                    slv_cnt++;
                    if (slv_cnt == 16) slv_phase = 4;
                end
                default: ;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic req, input logic [1:0] tgt,
                                 input logic [35:0] data, input logic [5:0] len);
        bus.i_req[r]     = req;
        bus.i_target[r]  = tgt;
        bus.i_tx_data[r] = data;
        bus.i_tx_len[r]  = len;
    endtask

    task automatic waitForDone(input int budget, output int n, output logic [1:0] g);
        n = 0;
        g = 2'b00;
        while (n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) g = bus.o_grant;
            if (bus.o_done != 2'b00) break;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        slv_ack = 1'b1;
        slv_len = 20;
        slv_resp = 16'h0005;
        mask_gen = 0;
        seen_gen = 0;
        nss_low_mask = 3'b000;
        slv_cap = '0;
        slv_cnt = 0;
        slv_phase = 0;
        rst = 1'b1;
        bus.i_req = 2'b00;
        bus.i_target = '0;
        bus.i_tx_data = '0;
        bus.i_tx_len = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_grant", 64'(bus.o_grant), 64'h0);
        checkOutput("rst_done", 64'(bus.o_done), 64'h0);
        checkOutput("rst_error", 64'(bus.o_error), 64'h0);
        checkOutput("rst_rx", 64'(bus.o_rx_data), 64'h0);
        checkOutput("rst_nss", 64'(bus.o_nss), 64'h7);
        checkOutput("rst_mosi", 64'(bus.o_mosi), 64'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: req0 ADD to ALU, 20 bits, response 0x0005
        $display("[TB] test 1: req0 to ALU");
        mask_gen++;
        applyStimulus(1'b0, 1'b1, 2'd0, 36'h1_0003_0002, 6'd20);
        waitForDone(200, cycles, first_grant);
        checkOutput("t1_grant", 64'(first_grant), 64'h1);
        checkOutput("t1_latency", 64'(cycles), 64'd40);
        checkOutput("t1_done", 64'(bus.o_done), 64'h1);
        checkOutput("t1_error", 64'(bus.o_error), 64'h0);
        checkOutput("t1_rx", 64'(bus.o_rx_data), 64'h0005);
        checkOutput("t1_mosi_bits", 64'(slv_cap), 64'h3_0002);
        checkOutput("t1_nss_used", 64'(nss_low_mask), 64'h1);
        checkOutput("t1_nss_after", 64'(bus.o_nss), 64'h7);
        checkOutput("t1_grant_clear", 64'(bus.o_grant), 64'h0);
        applyStimulus(1'b0, 1'b0, 2'd0, 36'h0, 6'd0);
        @(posedge clk);
        #1;
        checkOutput("t1_done_pulse", 64'(bus.o_done), 64'h0);

        // Test 3: req1 to MUL, peripheral never acknowledges
        $display("[TB] test 3: timeout in SEND");
        slv_ack = 1'b0;
        mask_gen++;
        applyStimulus(1'b1, 1'b1, 2'd2, 36'hFF, 6'd8);
        waitForDone(200, cycles, first_grant);
        checkOutput("t3_grant", 64'(first_grant), 64'h2);
        checkOutput("t3_latency", 64'(cycles), 64'd66);
        checkOutput("t3_done", 64'(bus.o_done), 64'h2);
        checkOutput("t3_error", 64'(bus.o_error), 64'h1);
        checkOutput("t3_rx", 64'(bus.o_rx_data), 64'h0);
        checkOutput("t3_nss_used", 64'(nss_low_mask), 64'h4);
        checkOutput("t3_nss_after", 64'(bus.o_nss), 64'h7);
        applyStimulus(1'b1, 1'b0, 2'd0, 36'h0, 6'd0);
        slv_ack = 1'b1;
        @(posedge clk);
        #1;

        // Test 2: both requesters held, grants alternate 0,1,0,1
        $display("[TB] test 2: round robin");
        slv_len = 4;
        slv_resp = 16'hA5C3;
        mask_gen++;
        applyStimulus(1'b0, 1'b1, 2'd0, 36'h5, 6'd4);
        applyStimulus(1'b1, 1'b1, 2'd0, 36'hA, 6'd4);
        for (int t = 0; t < 4; t++) begin
            waitForDone(200, cycles, first_grant);
            checkOutput($sformatf("t2_grant%0d", t), 64'(first_grant), (t % 2 == 0) ? 64'h1 : 64'h2);
            checkOutput($sformatf("t2_latency%0d", t), 64'(cycles), 64'd24);
            checkOutput($sformatf("t2_done%0d", t), 64'(bus.o_done), (t % 2 == 0) ? 64'h1 : 64'h2);
            checkOutput($sformatf("t2_rx%0d", t), 64'(bus.o_rx_data), 64'hA5C3);
            checkOutput($sformatf("t2_mosi%0d", t), 64'(slv_cap), (t % 2 == 0) ? 64'h5 : 64'hA);
            checkOutput($sformatf("t2_idle%0d", t), 64'(bus.o_grant), 64'h0);
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 36'h0, 6'd0);
        applyStimulus(1'b1, 1'b0, 2'd0, 36'h0, 6'd0);
        checkOutput("t2_nss_used", 64'(nss_low_mask), 64'h1);
        @(posedge clk);
        #1;

        // Test 4: bad target, then zero length
        $display("[TB] test 4: bad requests");
        mask_gen++;
        applyStimulus(1'b0, 1'b1, 2'd3, 36'h1, 6'd5);
        waitForDone(20, cycles, first_grant);
        checkOutput("t4a_latency", 64'(cycles), 64'd2);
        checkOutput("t4a_done", 64'(bus.o_done), 64'h1);
        checkOutput("t4a_error", 64'(bus.o_error), 64'h1);
        checkOutput("t4a_rx", 64'(bus.o_rx_data), 64'h0);
        applyStimulus(1'b0, 1'b0, 2'd0, 36'h0, 6'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 2'd0, 36'h1, 6'd0);
        waitForDone(20, cycles, first_grant);
        checkOutput("t4b_latency", 64'(cycles), 64'd2);
        checkOutput("t4b_done", 64'(bus.o_done), 64'h1);
        checkOutput("t4b_error", 64'(bus.o_error), 64'h1);
        applyStimulus(1'b0, 1'b0, 2'd0, 36'h0, 6'd0);
        checkOutput("t4_nss_used", 64'(nss_low_mask), 64'h0);
        @(posedge clk);
        #1;

        // Test 6: owner drops its request right after grant
        $display("[TB] test 6: request dropped mid-transaction");
        slv_len = 3;
        slv_resp = 16'h1234;
        applyStimulus(1'b0, 1'b1, 2'd0, 36'h3, 6'd3);
        @(posedge clk);
        #1;
        checkOutput("t6_grant", 64'(bus.o_grant), 64'h1);
        applyStimulus(1'b0, 1'b0, 2'd0, 36'h3, 6'd3);
        waitForDone(200, cycles, first_grant);
        checkOutput("t6_latency", 64'(cycles), 64'd22);
        checkOutput("t6_done", 64'(bus.o_done), 64'h1);
        checkOutput("t6_error", 64'(bus.o_error), 64'h0);
        checkOutput("t6_rx", 64'(bus.o_rx_data), 64'h1234);
        extra = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.o_done != 2'b00) extra++;
        end
        checkOutput("t6_single_pulse", 64'(extra), 64'h0);
        checkOutput("t6_rx_held", 64'(bus.o_rx_data), 64'h1234);

        // Test 5: reset during SENDING, then a clean transaction
        $display("[TB] test 5: reset mid-transaction");
        slv_len = 10;
        applyStimulus(1'b0, 1'b1, 2'd1, 36'h3FF, 6'd10);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput("t5_busy_nss", 64'(bus.o_nss), 64'h5);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_grant", 64'(bus.o_grant), 64'h0);
        checkOutput("t5_rst_done", 64'(bus.o_done), 64'h0);
        checkOutput("t5_rst_error", 64'(bus.o_error), 64'h0);
        checkOutput("t5_rst_rx", 64'(bus.o_rx_data), 64'h0);
        checkOutput("t5_rst_nss", 64'(bus.o_nss), 64'h7);
        checkOutput("t5_rst_mosi", 64'(bus.o_mosi), 64'h0);
        applyStimulus(1'b0, 1'b0, 2'd0, 36'h0, 6'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t5_no_done", 64'(bus.o_done), 64'h0);
        slv_len = 6;
        slv_resp = 16'h0F0F;
        mask_gen++;
        applyStimulus(1'b1, 1'b1, 2'd0, 36'h2D, 6'd6);
        waitForDone(200, cycles, first_grant);
        checkOutput("t5_grant", 64'(first_grant), 64'h2);
        checkOutput("t5_latency", 64'(cycles), 64'd26);
        checkOutput("t5_done", 64'(bus.o_done), 64'h2);
        checkOutput("t5_error", 64'(bus.o_error), 64'h0);
        checkOutput("t5_rx", 64'(bus.o_rx_data), 64'h0F0F);
        checkOutput("t5_mosi_bits", 64'(slv_cap), 64'h2D);
        applyStimulus(1'b1, 1'b0, 2'd0, 36'h0, 6'd0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
